// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types for the MIPS control pipeline (stage bundles, selects, forwarding helper).
package mips_decls_p;
    localparam int REGW = 5;
    typedef logic [REGW-1:0] regaddr_t;
    typedef enum logic [1:0] {MTR_ALU = 2'b00, MTR_MEM = 2'b01, MTR_PC4 = 2'b10} memtoreg_t;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    typedef struct packed {
        memtoreg_t  memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic       jump_r;
        logic [2:0] alucontrol;
        regaddr_t   rs;
        regaddr_t   rt;
        regaddr_t   rd;
    } ctrl_e_t;
    typedef struct packed {
        memtoreg_t memtoreg;
        logic      memwrite;
        logic      regwrite;
        regaddr_t  writereg;
    } ctrl_m_t;
    typedef struct packed {
        memtoreg_t memtoreg;
        logic      regwrite;
        regaddr_t  writereg;
    } ctrl_w_t;
    // Memory stage wins over Writeback; register 0 is hardwired and never forwards.
    function automatic fwd_sel_t fwd_sel(regaddr_t src, logic rw_m, regaddr_t wr_m, logic rw_w, regaddr_t wr_w);
        return (rw_m && wr_m != '0 && wr_m == src) ? FWD_MEM :
               (rw_w && wr_w != '0 && wr_w == src) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-side control bundle in, per-stage controls and hazard selects out.
interface ctrl_pipe_if #(parameter int REGW = 5, parameter int CNTW = 32);
    logic [1:0]      memtoreg_d;
    logic            memwrite_d, regwrite_d, alusrc_d, regdst_d, branch_d, jump_r_d;
    logic [2:0]      alucontrol_d;
    logic [REGW-1:0] rs_d, rt_d, rd_d;
    logic            zero_e;
    logic            alusrc_e, regdst_e;
    logic [2:0]      alucontrol_e;
    logic [REGW-1:0] writereg_e, writereg_m, writereg_w;
    logic            memwrite_m, regwrite_m;
    logic [1:0]      memtoreg_m;
    logic            regwrite_w;
    logic [1:0]      memtoreg_w;
    logic            pcsrc_e, jump_r_e;
    logic            stall_f, stall_d, flush_d;
    logic [1:0]      forward_a_e, forward_b_e;
    logic [CNTW-1:0] stall_cnt, flush_cnt;
    modport master (
        output memtoreg_d, memwrite_d, regwrite_d, alusrc_d, regdst_d, branch_d, jump_r_d,
               alucontrol_d, rs_d, rt_d, rd_d, zero_e,
        input  alusrc_e, regdst_e, alucontrol_e, writereg_e, writereg_m, writereg_w,
               memwrite_m, regwrite_m, memtoreg_m, regwrite_w, memtoreg_w, pcsrc_e, jump_r_e,
               stall_f, stall_d, flush_d, forward_a_e, forward_b_e, stall_cnt, flush_cnt
    );
    modport slave (
        input  memtoreg_d, memwrite_d, regwrite_d, alusrc_d, regdst_d, branch_d, jump_r_d,
               alucontrol_d, rs_d, rt_d, rd_d, zero_e,
        output alusrc_e, regdst_e, alucontrol_e, writereg_e, writereg_m, writereg_w,
               memwrite_m, regwrite_m, memtoreg_m, regwrite_w, memtoreg_w, pcsrc_e, jump_r_e,
               stall_f, stall_d, flush_d, forward_a_e, forward_b_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_hazard: combinational branch resolution, load-use stall and ALU-operand forwarding selects.
module ctrl_hazard
    import mips_decls_p::*;
(
    input  memtoreg_t memtoreg_e,
    input  logic      regwrite_e,
    input  logic      branch_e,
    input  logic      jump_r_e,
    input  logic      zero_e,
    input  regaddr_t  writereg_e,
    input  regaddr_t  rs_e,
    input  regaddr_t  rt_e,
    input  regaddr_t  rs_d,
    input  regaddr_t  rt_d,
    input  logic      regwrite_m,
    input  regaddr_t  writereg_m,
    input  logic      regwrite_w,
    input  regaddr_t  writereg_w,
    output logic      pcsrc,
    output logic      flush,
    output logic      stall,
    output logic      bubble,
    output fwd_sel_t  fwd_a,
    output fwd_sel_t  fwd_b
);
    logic lwstall;
    assign pcsrc   = branch_e & zero_e;
    assign flush   = pcsrc | jump_r_e;
    assign lwstall = (memtoreg_e == MTR_MEM) & regwrite_e & (writereg_e != '0) &
                     ((writereg_e == rs_d) | (writereg_e == rt_d));
    // A redirect kills the D instruction, so holding it would be pointless.
    assign stall   = lwstall & ~flush;
    assign bubble  = lwstall | flush;
    assign fwd_a   = fwd_sel(rs_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
    assign fwd_b   = fwd_sel(rt_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: E/M/W control pipeline registers with hazard unit for the 5-stage MIPS datapath.
// Optional stall/flush performance counters are built when CTRL_PIPE_PERF_CNT_EN is defined.
module ctrl_pipe
    import mips_decls_p::*;
#(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    ctrl_pipe_if.slave bus
);
    ctrl_e_t         e, e_d;
    ctrl_m_t         m;
    ctrl_w_t         w;
    logic [REGW-1:0] writereg_e;
    logic            pcsrc, flush, stall, bubble;
    fwd_sel_t        fwd_a, fwd_b;
    assign e_d = '{memtoreg: memtoreg_t'(bus.memtoreg_d), memwrite: bus.memwrite_d,
                   regwrite: bus.regwrite_d, alusrc: bus.alusrc_d, regdst: bus.regdst_d,
                   branch: bus.branch_d, jump_r: bus.jump_r_d, alucontrol: bus.alucontrol_d,
                   rs: bus.rs_d, rt: bus.rt_d, rd: bus.rd_d};
    assign writereg_e = e.regdst ? e.rd : e.rt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e <= '0;
            m <= '0;
            w <= '0;
        end else begin
            e <= bubble ? '0 : e_d;
            m <= '{memtoreg: e.memtoreg, memwrite: e.memwrite, regwrite: e.regwrite, writereg: writereg_e};
            w <= '{memtoreg: m.memtoreg, regwrite: m.regwrite, writereg: m.writereg};
        end
    end
    ctrl_hazard u_hazard (
        .memtoreg_e (e.memtoreg),
        .regwrite_e (e.regwrite),
        .branch_e   (e.branch),
        .jump_r_e   (e.jump_r),
        .zero_e     (bus.zero_e),
        .writereg_e (writereg_e),
        .rs_e       (e.rs),
        .rt_e       (e.rt),
        .rs_d       (bus.rs_d),
        .rt_d       (bus.rt_d),
        .regwrite_m (m.regwrite),
        .writereg_m (m.writereg),
        .regwrite_w (w.regwrite),
        .writereg_w (w.writereg),
        .pcsrc      (pcsrc),
        .flush      (flush),
        .stall      (stall),
        .bubble     (bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );
    assign bus.alusrc_e     = e.alusrc;
    assign bus.regdst_e     = e.regdst;
    assign bus.alucontrol_e = e.alucontrol;
    assign bus.writereg_e   = writereg_e;
    assign bus.memwrite_m   = m.memwrite;
    assign bus.regwrite_m   = m.regwrite;
    assign bus.memtoreg_m   = m.memtoreg;
    assign bus.writereg_m   = m.writereg;
    assign bus.regwrite_w   = w.regwrite;
    assign bus.memtoreg_w   = w.memtoreg;
    assign bus.writereg_w   = w.writereg;
    assign bus.pcsrc_e      = pcsrc;
    assign bus.jump_r_e     = e.jump_r;
    assign bus.stall_f      = stall;
    assign bus.stall_d      = stall;
    assign bus.flush_d      = flush;
    assign bus.forward_a_e  = fwd_a;
    assign bus.forward_b_e  = fwd_b;
`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt, flush_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNTW'(stall);
            flush_cnt <= flush_cnt + CNTW'(flush);
        end
    end
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`else
    assign bus.stall_cnt = {CNTW{1'b0}};
    assign bus.flush_cnt = {CNTW{1'b0}};
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed instruction stream with a writeback scoreboard and hazard-output checks.
module tb_ctrl_pipe;
    typedef struct packed {
        logic [1:0] mtr;
        logic       mw, rw, as, rdst, br, jr;
        logic [2:0] alu;
        logic [4:0] rs, rt, rd;
    } instr_t;
    typedef struct packed {
        int         due;
        logic       rw;
        logic [4:0] wr;
        logic [1:0] mtr;
    } sb_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    sb_t    sb[$];
    sb_t    mon;
    int     exp_st, exp_fl;
    logic [63:0] all_out;

    ctrl_pipe_if #(.REGW(5), .CNTW(32)) bus ();
    ctrl_pipe #(.REGW(5), .CNTW(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign all_out = {23'd0, bus.alusrc_e, bus.regdst_e, bus.alucontrol_e, bus.writereg_e,
                      bus.writereg_m, bus.writereg_w, bus.memwrite_m, bus.regwrite_m, bus.memtoreg_m,
                      bus.regwrite_w, bus.memtoreg_w, bus.pcsrc_e, bus.jump_r_e, bus.stall_f,
                      bus.stall_d, bus.flush_d, bus.forward_a_e, bus.forward_b_e};

    function automatic instr_t nop();
        return '0;
    endfunction
    function automatic instr_t add(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        instr_t i = '0;
        i.rw = 1'b1; i.rdst = 1'b1; i.alu = 3'b010; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction
    function automatic instr_t lw(logic [4:0] rt, logic [4:0] rs);
        instr_t i = '0;
        i.mtr = 2'b01; i.rw = 1'b1; i.as = 1'b1; i.alu = 3'b010; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic instr_t beq(logic [4:0] rs, logic [4:0] rt);
        instr_t i = '0;
        i.br = 1'b1; i.alu = 3'b110; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Killed instructions (stalled first copy, flushed D slot) reach W as an all-zero bubble.
    task automatic drive(input instr_t i, input bit killed = 1'b0, input bit z = 1'b0);
        sb_t s;
        bus.memtoreg_d = i.mtr; bus.memwrite_d = i.mw; bus.regwrite_d = i.rw;
        bus.alusrc_d = i.as; bus.regdst_d = i.rdst; bus.branch_d = i.br; bus.jump_r_d = i.jr;
        bus.alucontrol_d = i.alu; bus.rs_d = i.rs; bus.rt_d = i.rt; bus.rd_d = i.rd;
        bus.zero_e = z;
        s.due = cyc + 3;
        s.rw  = killed ? 1'b0 : i.rw;
        s.wr  = killed ? 5'd0 : (i.rdst ? i.rd : i.rt);
        s.mtr = killed ? 2'b00 : i.mtr;
        sb.push_back(s);
        #1;
    endtask

    task automatic go(input instr_t i, input bit killed = 1'b0, input bit z = 1'b0);
        @(posedge clk);
        #1;
        drive(i, killed, z);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon = sb.pop_front();
            chk("wb_stage", {59'd0, bus.regwrite_w, bus.writereg_w, bus.memtoreg_w},
                {59'd0, mon.rw, mon.wr, mon.mtr});
        end
    end

    initial begin
        instr_t junk;
        junk = lw(5'd7, 5'd7);
        junk.br = 1'b1; junk.jr = 1'b1; junk.mw = 1'b1; junk.rdst = 1'b1; junk.rd = 5'd9;
        bus.memtoreg_d = junk.mtr; bus.memwrite_d = junk.mw; bus.regwrite_d = junk.rw;
        bus.alusrc_d = junk.as; bus.regdst_d = junk.rdst; bus.branch_d = junk.br; bus.jump_r_d = junk.jr;
        bus.alucontrol_d = junk.alu; bus.rs_d = junk.rs; bus.rt_d = junk.rt; bus.rd_d = junk.rd;
        bus.zero_e = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("reset_outs", all_out, 64'd0);
        end
        chk("reset_cnt", {bus.stall_cnt, bus.flush_cnt}, 64'd0);
        reset_n = 1'b1;
        drive(add(5'd5, 5'd0, 5'd0));
        go(nop());
        chk("release_no_hazard", {61'd0, bus.stall_f, bus.stall_d, bus.flush_d}, 64'd0);
        chk("release_writereg_e", 64'(bus.writereg_e), 64'd5);
        go(nop());
        chk("release_w_not_yet", 64'(bus.regwrite_w), 64'd0);
        go(nop());
        chk("release_w", {62'd0, bus.regwrite_w, 1'b0} | 64'(bus.writereg_w) << 2, 64'd22);

        go(add(5'd3, 5'd1, 5'd2)); go(add(5'd4, 5'd3, 5'd3)); go(nop());
        chk("fwd_mem", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b1010);
        go(add(5'd3, 5'd1, 5'd2)); go(nop()); go(add(5'd4, 5'd3, 5'd3)); go(nop());
        chk("fwd_wb", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b0101);
        go(add(5'd3, 5'd1, 5'd2)); go(add(5'd3, 5'd2, 5'd2)); go(add(5'd4, 5'd3, 5'd3)); go(nop());
        chk("fwd_m_over_w", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b1010);
        go(add(5'd0, 5'd1, 5'd2)); go(add(5'd4, 5'd0, 5'd0)); go(nop());
        chk("fwd_r0", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b0000);
        go(add(5'd6, 5'd1, 5'd1)); go(add(5'd7, 5'd1, 5'd1)); go(add(5'd8, 5'd7, 5'd6)); go(nop());
        chk("fwd_mixed", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b1001);

        go(lw(5'd2, 5'd1)); go(add(5'd5, 5'd2, 5'd1), 1'b1);
        chk("lw_stall", {61'd0, bus.stall_f, bus.stall_d, bus.flush_d}, 64'b110);
        go(add(5'd5, 5'd2, 5'd1));
        chk("lw_stall_once", {61'd0, bus.stall_f, bus.stall_d, bus.flush_d}, 64'd0);
        chk("lw_e_bubble", {52'd0, bus.alusrc_e, bus.regdst_e, bus.alucontrol_e, bus.writereg_e,
                            bus.jump_r_e, bus.pcsrc_e}, 64'd0);
        go(nop());
        chk("lw_fwd_after", {60'd0, bus.forward_a_e, bus.forward_b_e}, 64'b0100);
        go(lw(5'd0, 5'd1)); go(add(5'd5, 5'd0, 5'd1));
        chk("lw_r0_no_stall", 64'(bus.stall_d), 64'd0);

        go(beq(5'd1, 5'd1)); go(add(5'd9, 5'd1, 5'd1), 1'b1, 1'b1);
        chk("br_taken", {61'd0, bus.pcsrc_e, bus.flush_d, bus.stall_d}, 64'b110);
        go(nop());
        chk("br_e_cleared", {52'd0, bus.alusrc_e, bus.regdst_e, bus.alucontrol_e, bus.writereg_e,
                             bus.pcsrc_e, bus.flush_d}, 64'd0);
        go(beq(5'd1, 5'd2)); go(add(5'd9, 5'd1, 5'd1));
        chk("br_not_taken", {62'd0, bus.pcsrc_e, bus.flush_d}, 64'd0);
        go(nop());
        chk("br_nt_next", 64'(bus.writereg_e), 64'd9);

        junk = lw(5'd2, 5'd1);
        junk.jr = 1'b1;
        go(junk); go(add(5'd5, 5'd2, 5'd1), 1'b1);
        chk("collide", {60'd0, bus.jump_r_e, bus.flush_d, bus.stall_f, bus.stall_d}, 64'b1100);
        go(nop());
        chk("collide_e_cleared", {53'd0, bus.regdst_e, bus.alucontrol_e, bus.writereg_e, bus.jump_r_e}, 64'd0);

        for (int k = 0; k < 2; k++) begin
            go(lw(5'd2, 5'd1)); go(add(5'd5, 5'd1, 5'd2), 1'b1);
            chk("lw_stall_rt", 64'(bus.stall_d), 64'd1);
            go(add(5'd5, 5'd1, 5'd2));
        end
        go(nop()); go(nop());
`ifdef CTRL_PIPE_PERF_CNT_EN
        exp_st = 3; exp_fl = 2;
`else
        exp_st = 0; exp_fl = 0;
`endif
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(exp_st));
        chk("flush_cnt", 64'(bus.flush_cnt), 64'(exp_fl));
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
